// File: rtl/xcheck_sched.sv
// Round-robin scheduler that shares one X-check unit among CH_NUM channels.
// It collects the checker verdicts into sticky flags, a saturating counter, a first-offender ID and an irq.
module xcheck_sched #(
    parameter int CH_NUM      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int HALT_ON_ERR = 1,
    localparam int ID_W       = $clog2(CH_NUM)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic [CH_NUM-1:0]            req_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0] dat_i,
    output logic [CH_NUM-1:0]            gnt_o,
    output logic                         chk_vld_o,
    output logic [DATA_WIDTH-1:0]        chk_dat_o,
    output logic [ID_W-1:0]              chk_id_o,
    input  logic                         chk_err_i,
    output logic [CH_NUM-1:0]            err_flag_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    output logic [ID_W-1:0]              first_id_o,
    output logic                         irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_TRIP} state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_ptr;
    logic                   r_vld;
    logic [DATA_WIDTH-1:0]  r_dat;
    logic [ID_W-1:0]        r_id;
    logic [CH_NUM-1:0]      r_flag;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [ID_W-1:0]        r_first;
    logic                   r_irq;

    logic [DATA_WIDTH-1:0]  w_words [CH_NUM];
    logic                   w_hit;
    logic [ID_W-1:0]        w_win;
    logic [ID_W-1:0]        w_ptr_nxt;
    logic                   w_err;
    logic                   w_trip;
    logic                   w_any;
    logic [CH_NUM-1:0]      w_gnt;

    // Scan downward from the farthest offset so the nearest requester at/after the pointer wins.
    function automatic logic [ID_W:0] pick(input logic [CH_NUM-1:0] req, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % CH_NUM;
            if (req[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            w_words[k] = dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A verdict that trips the halt blocks any grant in that same cycle; clr_i overrides it.
    assign w_err  = r_vld && chk_err_i;
    assign w_trip = (HALT_ON_ERR != 0) && (r_state == ST_SCAN) && w_err && !clr_i;
    assign {w_hit, w_win} = pick(req_i, r_ptr);
    assign w_any  = (r_state == ST_SCAN) && en_i && !w_trip && w_hit;
    assign w_ptr_nxt = (w_win == ID_W'(CH_NUM - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_gnt = '0;
        if (w_any) w_gnt[w_win] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_vld   <= 1'b0;
            r_dat   <= '0;
            r_id    <= '0;
            r_flag  <= '0;
            r_cnt   <= '0;
            r_first <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_vld <= w_any;
            if (w_any) begin
                r_dat <= w_words[w_win];
                r_id  <= w_win;
                r_ptr <= w_ptr_nxt;
            end

            if (clr_i) begin
                r_flag  <= '0;
                r_cnt   <= '0;
                r_first <= '0;
                r_irq   <= 1'b0;
            end else if (w_err) begin
                r_flag[r_id] <= 1'b1;
                if (r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + 1'b1;
                if (!r_irq) begin
                    r_first <= r_id;
                    r_irq   <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: if (en_i) r_state <= ST_SCAN;
                ST_SCAN: begin
                    if (w_trip)     r_state <= ST_TRIP;
                    else if (!en_i) r_state <= ST_IDLE;
                end
                ST_TRIP: if (clr_i) r_state <= en_i ? ST_SCAN : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o      = w_gnt;
    assign chk_vld_o  = r_vld;
    assign chk_dat_o  = r_dat;
    assign chk_id_o   = r_id;
    assign err_flag_o = r_flag;
    assign err_cnt_o  = r_cnt;
    assign first_id_o = r_first;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_xcheck_sched.sv
// Directed bench for xcheck_sched: a halting instance (u0) and a non-halting 2-bit-counter instance (u1)
// share the same stimulus.
module tb_xcheck_sched;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, clr_i, chk_err_i;
    logic [N-1:0]  req_i;
    logic [N*DW-1:0] dat_i;

    logic [N-1:0]  gnt0, flag0, gnt1, flag1;
    logic          vld0, irq0, vld1, irq1;
    logic [DW-1:0] cdat0, cdat1;
    logic [1:0]    id0, first0, id1, first1;
    logic [15:0]   cnt0;
    logic [1:0]    cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    xcheck_sched #(.CH_NUM(4), .DATA_WIDTH(32), .CNT_WIDTH(16), .HALT_ON_ERR(1)) u0 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .req_i(req_i), .dat_i(dat_i),
        .gnt_o(gnt0), .chk_vld_o(vld0), .chk_dat_o(cdat0), .chk_id_o(id0), .chk_err_i(chk_err_i),
        .err_flag_o(flag0), .err_cnt_o(cnt0), .first_id_o(first0), .irq_o(irq0));

    xcheck_sched #(.CH_NUM(4), .DATA_WIDTH(32), .CNT_WIDTH(2), .HALT_ON_ERR(0)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .req_i(req_i), .dat_i(dat_i),
        .gnt_o(gnt1), .chk_vld_o(vld1), .chk_dat_o(cdat1), .chk_id_o(id1), .chk_err_i(chk_err_i),
        .err_flag_o(flag1), .err_cnt_o(cnt1), .first_id_o(first1), .irq_o(irq1));

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; chk_err_i = 1'b0; req_i = 4'b1111;
        for (int k = 0; k < N; k++) dat_i[k*DW +: DW] = 32'hC0DE_0000 + k;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        n_cmp++; if ({vld0, cdat0, id0} !== '0) begin n_bad++; $display("FAIL reset_chk got vld=%b dat=%h id=%0d want 0", vld0, cdat0, id0); end
        n_cmp++; if ({flag0, cnt0, first0, irq0} !== '0) begin n_bad++; $display("FAIL reset_status got flag=%b cnt=%0d first=%0d irq=%b want 0", flag0, cnt0, first0, irq0); end
        n_cmp++; if (gnt0 !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt_idle got %b want 0000", gnt0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        en_i = 1'b1; req_i = 4'b1111;
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            n_cmp++; if (gnt0 !== exp_g) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", i, gnt0, exp_g); end
            if (i > 0) begin
                n_cmp++;
                if (vld0 !== 1'b1 || id0 !== 2'((i - 1) % 4) || cdat0 !== 32'hC0DE_0000 + (i - 1) % 4) begin
                    n_bad++; $display("FAIL rr_chk[%0d] got vld=%b id=%0d dat=%h want 1/%0d", i, vld0, id0, cdat0, (i - 1) % 4);
                end
            end
            tick();
        end
        n_cmp++; if (vld0 !== 1'b1 || id0 !== 2'd3 || cdat0 !== 32'hC0DE_0003) begin n_bad++; $display("FAIL rr_last got vld=%b id=%0d dat=%h want 1/3/c0de0003", vld0, id0, cdat0); end
        en_i = 1'b0; req_i = 4'b0000;
        tick();
        n_cmp++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL rr_drain_vld got %b want 0", vld0); end
    endtask

    task automatic test_skip_idle();
        en_i = 1'b1; req_i = 4'b1010;
        tick();
        n_cmp++; if (gnt0 !== 4'b0010) begin n_bad++; $display("FAIL skip_g0 got %b want 0010", gnt0); end
        tick();
        n_cmp++; if (gnt0 !== 4'b1000) begin n_bad++; $display("FAIL skip_g1 got %b want 1000", gnt0); end
        tick();
        n_cmp++; if (gnt0 !== 4'b0010) begin n_bad++; $display("FAIL skip_g2 got %b want 0010", gnt0); end
        en_i = 1'b0; req_i = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_error_halt();
        en_i = 1'b1; req_i = 4'b0100;
        tick();
        n_cmp++; if (gnt0 !== 4'b0100) begin n_bad++; $display("FAIL err_gnt2 got %b want 0100", gnt0); end
        tick();
        n_cmp++; if (vld0 !== 1'b1 || id0 !== 2'd2 || cdat0 !== 32'hC0DE_0002) begin n_bad++; $display("FAIL err_word got vld=%b id=%0d dat=%h want 1/2/c0de0002", vld0, id0, cdat0); end
        chk_err_i = 1'b1; req_i = 4'b1111;
        #1;
        n_cmp++; if (gnt0 !== 4'b0000) begin n_bad++; $display("FAIL err_trip_nogrant got %b want 0000", gnt0); end
        n_cmp++; if (gnt1 !== 4'b1000) begin n_bad++; $display("FAIL err_nohalt_grant got %b want 1000", gnt1); end
        tick();
        chk_err_i = 1'b0;
        n_cmp++; if (flag0 !== 4'b0100 || cnt0 !== 16'd1 || first0 !== 2'd2 || irq0 !== 1'b1) begin
            n_bad++; $display("FAIL err_status got flag=%b cnt=%0d first=%0d irq=%b want 0100/1/2/1", flag0, cnt0, first0, irq0);
        end
        n_cmp++; if (cnt1 !== 2'd1 || irq1 !== 1'b1 || first1 !== 2'd2) begin n_bad++; $display("FAIL err_status_u1 got cnt=%0d irq=%b first=%0d want 1/1/2", cnt1, irq1, first1); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (gnt0 !== 4'b0000 || vld0 !== 1'b0) begin n_bad++; $display("FAIL halt_hold[%0d] got gnt=%b vld=%b want 0000/0", i, gnt0, vld0); end
            tick();
        end
    endtask

    task automatic test_clear_priority();
        clr_i = 1'b1; chk_err_i = 1'b1;
        #1;
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL clr_u1_vld got %b want 1", vld1); end
        tick();
        clr_i = 1'b0; chk_err_i = 1'b0;
        n_cmp++; if ({flag0, cnt0, first0, irq0} !== '0) begin n_bad++; $display("FAIL clr_u0 got flag=%b cnt=%0d first=%0d irq=%b want 0", flag0, cnt0, first0, irq0); end
        n_cmp++; if ({flag1, cnt1, first1, irq1} !== '0) begin n_bad++; $display("FAIL clr_beats_err got flag=%b cnt=%0d first=%0d irq=%b want 0", flag1, cnt1, first1, irq1); end
        #1;
        n_cmp++; if (gnt0 !== 4'b1000) begin n_bad++; $display("FAIL clr_leave_trip got %b want 1000", gnt0); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        en_i = 1'b0; req_i = 4'b0000;
        tick(); tick();
        en_i = 1'b1;
        tick();
        req_i = 4'b0010;
        #1;
        n_cmp++; if (gnt1 !== 4'b0010) begin n_bad++; $display("FAIL sat_gnt got %b want 0010", gnt1); end
        tick();
        n_cmp++; if (vld1 !== 1'b1 || id1 !== 2'd1) begin n_bad++; $display("FAIL sat_word got vld=%b id=%0d want 1/1", vld1, id1); end
        chk_err_i = 1'b1; req_i = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (cnt1 !== exp_c[i] || first1 !== 2'd1 || irq1 !== 1'b1) begin
                n_bad++; $display("FAIL sat_cnt[%0d] got cnt=%0d first=%0d irq=%b want %0d/1/1", i, cnt1, first1, irq1, exp_c[i]);
            end
        end
        chk_err_i = 1'b0;
        n_cmp++; if (flag1 !== 4'b1010) begin n_bad++; $display("FAIL sat_flags got %b want 1010", flag1); end
    endtask

    task automatic test_reset_midrun();
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_vld got %b want 1", vld1); end
        rst_i = 1'b1; chk_err_i = 1'b1; req_i = 4'b1111;
        tick();
        rst_i = 1'b0; chk_err_i = 1'b0;
        n_cmp++; if ({gnt1, vld1, cdat1, id1, flag1, cnt1, first1, irq1} !== '0) begin
            n_bad++; $display("FAIL rst_mid_u1 got gnt=%b vld=%b dat=%h id=%0d flag=%b cnt=%0d first=%0d irq=%b want 0", gnt1, vld1, cdat1, id1, flag1, cnt1, first1, irq1);
        end
        n_cmp++; if ({gnt0, vld0, cdat0, id0, flag0, cnt0, first0, irq0} !== '0) begin
            n_bad++; $display("FAIL rst_mid_u0 got gnt=%b vld=%b dat=%h id=%0d flag=%b cnt=%0d first=%0d irq=%b want 0", gnt0, vld0, cdat0, id0, flag0, cnt0, first0, irq0);
        end
        tick();
        n_cmp++; if (gnt0 !== 4'b0001 || gnt1 !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt got u0=%b u1=%b want 0001", gnt0, gnt1); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip_idle();
        test_error_halt();
        test_clear_priority();
        test_saturate();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
